// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side upsizer: default geometry,
// lane-counter type and lane-mask helpers.
package fifo_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int RATIO_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  localparam int CNT_W = $clog2(RATIO_DEF);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [RATIO_DEF-1:0] KEEP_ALL = {RATIO_DEF{1'b1}};

  // Mask with the low n bits set; n is always below the lane count.
  function automatic logic [31:0] low_mask(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle counter: cleared by i_clear, otherwise counts up and parks at
// TIMEOUT-1, where o_expired is asserted.
module fifo_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_timer;

  assign o_expired = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (!o_expired) begin
      r_timer <= r_timer + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_upsizer.sv
// Packs RATIO show-ahead FIFO words into one registered valid/ready beat.
// FIFO_UPSIZER_TIMEOUT_EN adds an idle flush of partial beats and m_keep.
module fifo_rd_upsizer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RATIO   = RATIO_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   r_clk,
  input  logic                   r_rst_n,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_dat,
  input  logic                   fifo_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*RATIO-1:0] m_dat
`ifdef FIFO_UPSIZER_TIMEOUT_EN
  ,
  output logic [RATIO-1:0]       m_keep
`endif
);

  localparam int CW = $clog2(RATIO);
  localparam int AW = WIDTH * (RATIO - 1);

  if (TIMEOUT < 1 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_param_check
    $error("fifo_rd_upsizer: illegal RATIO/TIMEOUT");
  end

  logic [CW-1:0]          r_cnt;
  logic [AW-1:0]          r_acc;
  logic                   r_valid;
  logic [WIDTH*RATIO-1:0] r_dat;
  logic                   w_out_free;
  logic                   w_last;
  logic                   w_pop;
  logic                   w_flush;

  // Valid/ready: a beat moves on any edge with m_valid && m_ready; while
  // m_valid is high and m_ready low, m_dat/m_keep hold. Only the final lane
  // waits for the output slot, so earlier lanes keep filling under stall.
  assign w_out_free = !r_valid || m_ready;
  assign w_last     = (r_cnt == CW'(RATIO - 1));
  assign w_pop      = r_rst_n && !fifo_empty && (!w_last || w_out_free);
  assign fifo_rd_en = w_pop;
  assign m_valid    = r_valid;
  assign m_dat      = r_dat;

`ifdef FIFO_UPSIZER_TIMEOUT_EN
  logic             w_expired;
  logic [RATIO-1:0] r_keep;

  fifo_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .i_clk     (r_clk),
    .i_rst_n   (r_rst_n),
    .i_clear   (w_pop || (r_cnt == '0) || w_flush),
    .o_expired (w_expired)
  );

  assign w_flush = w_expired && w_out_free && !w_pop && (r_cnt != '0);
  assign m_keep  = r_keep;
`else
  assign w_flush = 1'b0;
`endif

  // Accumulator is zeroed on every beat so a flushed partial has clean upper lanes.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_dat   <= '0;
`ifdef FIFO_UPSIZER_TIMEOUT_EN
      r_keep  <= '0;
`endif
    end else begin
      if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
      if (w_pop && w_last) begin
        r_dat   <= {fifo_dat, r_acc};
        r_valid <= 1'b1;
        r_cnt   <= '0;
        r_acc   <= '0;
`ifdef FIFO_UPSIZER_TIMEOUT_EN
        r_keep  <= {RATIO{1'b1}};
`endif
      end else if (w_pop) begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (r_cnt == CW'(i)) begin
            r_acc[i*WIDTH +: WIDTH] <= fifo_dat;
          end
        end
        r_cnt <= r_cnt + 1'b1;
      end else if (w_flush) begin
        r_dat   <= {{WIDTH{1'b0}}, r_acc};
        r_valid <= 1'b1;
        r_cnt   <= '0;
        r_acc   <= '0;
`ifdef FIFO_UPSIZER_TIMEOUT_EN
        r_keep  <= RATIO'(low_mask(32'(r_cnt)));
`endif
      end
    end
  end

endmodule
